// File: rtl/id_stage_pkg.sv
// id_stage_pkg: bus widths, opcode/funct encodings and packed bus layouts for the decode stage
package id_stage_pkg;
  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int DS_TO_ES_BUS_WD = 137;
  localparam int BR_BUS_WD = 34;
  localparam int WS_TO_RF_BUS_WD = 38;
  localparam int ES_FWD_BUS_WD = 39;
  localparam int MS_FWD_BUS_WD = 38;
  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_JAL = 6'h03,
    OP_BEQ = 6'h04,
    OP_BNE = 6'h05,
    OP_ADDIU = 6'h09,
    OP_LUI = 6'h0f,
    OP_LW = 6'h23,
    OP_SW = 6'h2b
  } opcode_e;
  typedef enum logic [5:0] {
    FN_SLL = 6'h00,
    FN_SRL = 6'h02,
    FN_SRA = 6'h03,
    FN_JR = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND = 6'h24,
    FN_OR = 6'h25,
    FN_XOR = 6'h26,
    FN_NOR = 6'h27,
    FN_SLT = 6'h2a,
    FN_SLTU = 6'h2b
  } funct_e;
  typedef struct packed {
    logic [11:0] alu_op;
    logic load_op;
    logic mem_we;
    logic src1_is_sa;
    logic src1_is_pc;
    logic src2_is_simm;
    logic src2_is_zimm;
    logic src2_is_8;
    logic gr_we;
    logic [4:0] dest;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_to_es_t;
  typedef struct packed {
    logic valid;
    logic is_load;
    logic [4:0] dest;
    logic [31:0] result;
  } es_fwd_t;
  typedef struct packed {
    logic valid;
    logic [4:0] dest;
    logic [31:0] result;
  } ms_fwd_t;
  typedef struct packed {
    logic we;
    logic [4:0] waddr;
    logic [31:0] wdata;
  } ws_rf_t;
  // Youngest producer wins; a load still in EX has no data yet and is left to the stall logic.
  function automatic logic [31:0] fwd_sel(input logic [4:0] r, input es_fwd_t es, input ms_fwd_t ms,
                                          input ws_rf_t ws, input logic [31:0] rf);
    return r == 5'd0 ? 32'd0 :
           (es.valid && !es.is_load && es.dest == r) ? es.result :
           (ms.valid && ms.dest == r) ? ms.result :
           (ws.we && ws.waddr == r) ? ws.wdata : rf;
  endfunction
endpackage

// File: rtl/id_stage_regfile.sv
// id_stage_regfile: 32x32 register file, two async read ports, one sync write port, r0 reads 0
module id_stage_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  always_comb begin
    regs_d = regs_q;
    if (we && waddr != 5'd0) regs_d[waddr] = wdata;
    rdata1 = raddr1 == 5'd0 ? 32'd0 : regs_q[raddr1];
    rdata2 = raddr2 == 5'd0 ? 32'd0 : regs_q[raddr2];
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode stage with operand forwarding, load-use stall and branch resolution
module id_stage
  import id_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_allowin,
  input  logic                       es_allowin,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [BR_BUS_WD-1:0]       br_bus,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  input  logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);
  logic ds_valid_q, ds_valid_d, ds_valid, ds_ready_go, load_use;
  logic [31:0] ds_inst_q, ds_inst_d, ds_pc_q, ds_pc_d;
  logic [5:0] op, func;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  logic i_addu, i_subu, i_slt, i_sltu, i_and, i_or, i_xor, i_nor, i_sll, i_srl, i_sra, i_jr;
  logic i_addiu, i_lui, i_lw, i_sw, i_beq, i_bne, i_jal, is_r, r_alu, shift;
  logic reads_rs, reads_rt, gr_we, br_cond, br_taken, br_stall;
  logic [4:0] dest;
  logic [31:0] rf_rdata1, rf_rdata2, rs_value, rt_value, pc_plus4, br_target;
  es_fwd_t es;
  ms_fwd_t ms;
  ws_rf_t ws;
  ds_to_es_t pkt;
  id_stage_regfile u_regfile (
    .clk    (clk),
    .rst    (reset),
    .we     (ws.we),
    .waddr  (ws.waddr),
    .wdata  (ws.wdata),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );
  always_comb begin
    es = es_fwd_bus;
    ms = ms_fwd_bus;
    ws = ws_to_rf_bus;
    // Reset masks the stage combinationally so outputs are idle during the reset cycle itself.
    ds_valid = ds_valid_q && !reset;
    op = ds_inst_q[31:26];
    rs = ds_inst_q[25:21];
    rt = ds_inst_q[20:16];
    rd = ds_inst_q[15:11];
    func = ds_inst_q[5:0];
    imm = ds_inst_q[15:0];
    is_r = op == OP_SPECIAL;
    i_addu = is_r && func == FN_ADDU;
    i_subu = is_r && func == FN_SUBU;
    i_slt = is_r && func == FN_SLT;
    i_sltu = is_r && func == FN_SLTU;
    i_and = is_r && func == FN_AND;
    i_or = is_r && func == FN_OR;
    i_xor = is_r && func == FN_XOR;
    i_nor = is_r && func == FN_NOR;
    i_sll = is_r && func == FN_SLL;
    i_srl = is_r && func == FN_SRL;
    i_sra = is_r && func == FN_SRA;
    i_jr = is_r && func == FN_JR;
    i_addiu = op == OP_ADDIU;
    i_lui = op == OP_LUI;
    i_lw = op == OP_LW;
    i_sw = op == OP_SW;
    i_beq = op == OP_BEQ;
    i_bne = op == OP_BNE;
    i_jal = op == OP_JAL;
    r_alu = i_addu || i_subu || i_slt || i_sltu || i_and || i_or || i_xor || i_nor;
    shift = i_sll || i_srl || i_sra;
    reads_rs = r_alu || i_jr || i_addiu || i_lw || i_sw || i_beq || i_bne;
    reads_rt = r_alu || shift || i_sw || i_beq || i_bne;
    gr_we = r_alu || shift || i_addiu || i_lui || i_lw || i_jal;
    dest = !gr_we ? 5'd0 : i_jal ? 5'd31 : (i_addiu || i_lui || i_lw) ? rt : rd;
    rs_value = fwd_sel(rs, es, ms, ws, rf_rdata1);
    rt_value = fwd_sel(rt, es, ms, ws, rf_rdata2);
    load_use = ds_valid && es.valid && es.is_load && es.dest != 5'd0 &&
               ((reads_rs && es.dest == rs) || (reads_rt && es.dest == rt));
    ds_ready_go = !load_use;
    ds_allowin = !ds_valid || (ds_ready_go && es_allowin);
    ds_to_es_valid = ds_valid && ds_ready_go;
    pc_plus4 = ds_pc_q + 32'd4;
    br_cond = (i_beq && rs_value == rt_value) || (i_bne && rs_value != rt_value) || i_jal || i_jr;
    br_taken = ds_valid && ds_ready_go && br_cond;
    br_stall = ds_valid && (i_beq || i_bne || i_jal || i_jr) && load_use;
    br_target = !br_taken ? 32'd0 : i_jr ? rs_value :
                i_jal ? {pc_plus4[31:28], ds_inst_q[25:0], 2'b00} :
                pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    br_bus = {br_stall, br_taken, br_target};
    pkt.alu_op = {i_lui, i_sra, i_srl, i_sll, i_xor, i_or, i_nor, i_and, i_sltu, i_slt, i_subu,
                  i_addu || i_addiu || i_lw || i_sw || i_jal};
    pkt.load_op = i_lw;
    pkt.mem_we = i_sw;
    pkt.src1_is_sa = shift;
    pkt.src1_is_pc = i_jal;
    pkt.src2_is_simm = i_addiu || i_lui || i_lw || i_sw;
    pkt.src2_is_zimm = 1'b0;
    pkt.src2_is_8 = i_jal;
    pkt.gr_we = gr_we;
    pkt.dest = dest;
    pkt.imm = imm;
    pkt.rs_value = rs_value;
    pkt.rt_value = rt_value;
    pkt.pc = ds_pc_q;
    ds_to_es_bus = pkt;
    ds_valid_d = flush ? 1'b0 : ds_allowin ? fs_to_ds_valid : ds_valid_q;
    ds_inst_d = (ds_allowin && fs_to_ds_valid) ? fs_to_ds_bus[63:32] : ds_inst_q;
    ds_pc_d = (ds_allowin && fs_to_ds_valid) ? fs_to_ds_bus[31:0] : ds_pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      ds_inst_q <= '0;
      ds_pc_q <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_inst_q <= ds_inst_d;
      ds_pc_q <= ds_pc_d;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage
module tb_id_stage;
  logic clk = 1'b0;
  logic reset, flush, fs_to_ds_valid, es_allowin, ds_allowin, ds_to_es_valid;
  logic [63:0] fs_to_ds_bus;
  logic [136:0] ds_to_es_bus;
  logic [33:0] br_bus;
  logic [37:0] ws_to_rf_bus, ms_fwd_bus;
  logic [38:0] es_fwd_bus;
  int vec_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] f_pc, f_rt, f_rs;
  logic [15:0] f_imm;
  logic [4:0] f_dest;
  logic f_gr_we, f_src2_is_8, f_simm, f_src1_is_pc, f_mem_we;
  logic [11:0] f_alu_op;
  assign f_pc = ds_to_es_bus[31:0];
  assign f_rt = ds_to_es_bus[63:32];
  assign f_rs = ds_to_es_bus[95:64];
  assign f_imm = ds_to_es_bus[111:96];
  assign f_dest = ds_to_es_bus[116:112];
  assign f_gr_we = ds_to_es_bus[117];
  assign f_src2_is_8 = ds_to_es_bus[118];
  assign f_simm = ds_to_es_bus[120];
  assign f_src1_is_pc = ds_to_es_bus[121];
  assign f_mem_we = ds_to_es_bus[123];
  assign f_alu_op = ds_to_es_bus[136:125];

  id_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus), .ds_allowin(ds_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus), .br_bus(br_bus),
    .ws_to_rf_bus(ws_to_rf_bus), .es_fwd_bus(es_fwd_bus), .ms_fwd_bus(ms_fwd_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] inst, input logic [31:0] pc);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = {inst, pc};
    tick();
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus = '0;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ws_to_rf_bus = {1'b1, a, d};
    tick();
    ws_to_rf_bus = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; es_allowin = 1'b1;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = {32'h24010005, 32'h1000};
    ws_to_rf_bus = '0; es_fwd_bus = '0; ms_fwd_bus = '0;
    tick(); tick(); #1;
    vec_cnt++; if (ds_allowin !== 1'b1) begin fail_cnt++; $display("FAIL rst_allowin got %b want 1", ds_allowin); end
    vec_cnt++; if (ds_to_es_valid !== 1'b0) begin fail_cnt++; $display("FAIL rst_valid got %b want 0", ds_to_es_valid); end
    vec_cnt++; if (br_bus !== 34'd0) begin fail_cnt++; $display("FAIL rst_br got %h want 0", br_bus); end
    reset = 1'b0; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0;
    tick();
    vec_cnt++; if (ds_to_es_valid !== 1'b0) begin fail_cnt++; $display("FAIL post_rst_valid got %b want 0", ds_to_es_valid); end
  endtask

  task automatic test_addiu();
    load(32'h24010005, 32'hbfc00000);
    vec_cnt++; if (ds_to_es_valid !== 1'b1) begin fail_cnt++; $display("FAIL addiu_valid got %b want 1", ds_to_es_valid); end
    vec_cnt++; if (f_dest !== 5'd1) begin fail_cnt++; $display("FAIL addiu_dest got %0d want 1", f_dest); end
    vec_cnt++; if (f_gr_we !== 1'b1) begin fail_cnt++; $display("FAIL addiu_gr_we got %b want 1", f_gr_we); end
    vec_cnt++; if (f_simm !== 1'b1) begin fail_cnt++; $display("FAIL addiu_simm got %b want 1", f_simm); end
    vec_cnt++; if (f_imm !== 16'h0005) begin fail_cnt++; $display("FAIL addiu_imm got %h want 0005", f_imm); end
    vec_cnt++; if (f_pc !== 32'hbfc00000) begin fail_cnt++; $display("FAIL addiu_pc got %h want bfc00000", f_pc); end
    vec_cnt++; if (f_alu_op !== 12'h001) begin fail_cnt++; $display("FAIL addiu_alu got %h want 001", f_alu_op); end
    tick();
    vec_cnt++; if (ds_to_es_valid !== 1'b0) begin fail_cnt++; $display("FAIL addiu_drain got %b want 0", ds_to_es_valid); end
  endtask

  task automatic test_regfile();
    wr(5'd5, 32'd1); wr(5'd6, 32'd2); wr(5'd7, 32'h80001234); wr(5'd0, 32'hdeadbeef);
    es_allowin = 1'b0;
    load(32'h00A61821, 32'h20);
    vec_cnt++; if (f_rs !== 32'd1) begin fail_cnt++; $display("FAIL rf_rs got %h want 1", f_rs); end
    vec_cnt++; if (f_rt !== 32'd2) begin fail_cnt++; $display("FAIL rf_rt got %h want 2", f_rt); end
    ws_to_rf_bus = {1'b1, 5'd5, 32'h77}; #1;
    vec_cnt++; if (f_rs !== 32'h77) begin fail_cnt++; $display("FAIL ws_fwd got %h want 77", f_rs); end
    ws_to_rf_bus = '0; es_allowin = 1'b1;
    tick();
    es_allowin = 1'b0;
    load(32'h00001821, 32'h24);
    ws_to_rf_bus = {1'b1, 5'd0, 32'h1111}; es_fwd_bus = {2'b10, 5'd0, 32'h2222}; ms_fwd_bus = {1'b1, 5'd0, 32'h3333}; #1;
    vec_cnt++; if (f_rs !== 32'd0) begin fail_cnt++; $display("FAIL r0_rs got %h want 0", f_rs); end
    vec_cnt++; if (f_rt !== 32'd0) begin fail_cnt++; $display("FAIL r0_rt got %h want 0", f_rt); end
    ws_to_rf_bus = '0; es_fwd_bus = '0; ms_fwd_bus = '0; es_allowin = 1'b1;
    tick();
  endtask

  task automatic test_fwd();
    es_allowin = 1'b0;
    load(32'h00421821, 32'h40);
    es_fwd_bus = {2'b10, 5'd2, 32'hAAAA}; ms_fwd_bus = {1'b1, 5'd2, 32'hBBBB}; #1;
    vec_cnt++; if (f_rs !== 32'hAAAA) begin fail_cnt++; $display("FAIL fwd_es_rs got %h want aaaa", f_rs); end
    vec_cnt++; if (f_rt !== 32'hAAAA) begin fail_cnt++; $display("FAIL fwd_es_rt got %h want aaaa", f_rt); end
    es_fwd_bus = {2'b11, 5'd2, 32'hAAAA}; #1;
    vec_cnt++; if (f_rs !== 32'hBBBB) begin fail_cnt++; $display("FAIL fwd_skip_load got %h want bbbb", f_rs); end
    vec_cnt++; if (ds_to_es_valid !== 1'b0) begin fail_cnt++; $display("FAIL lu_valid got %b want 0", ds_to_es_valid); end
    es_fwd_bus = '0; #1;
    vec_cnt++; if (f_rt !== 32'hBBBB) begin fail_cnt++; $display("FAIL fwd_ms got %h want bbbb", f_rt); end
    vec_cnt++; if (ds_to_es_valid !== 1'b1) begin fail_cnt++; $display("FAIL fwd_valid got %b want 1", ds_to_es_valid); end
    ms_fwd_bus = '0; ws_to_rf_bus = {1'b1, 5'd2, 32'hCCCC}; #1;
    vec_cnt++; if (f_rt !== 32'hCCCC) begin fail_cnt++; $display("FAIL fwd_ws got %h want cccc", f_rt); end
    ws_to_rf_bus = '0; es_allowin = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    es_fwd_bus = {2'b11, 5'd4, 32'd0};
    load(32'h10800003, 32'h200);
    vec_cnt++; if (br_bus !== {1'b1, 1'b0, 32'd0}) begin fail_cnt++; $display("FAIL lu_br got %h want 200000000", br_bus); end
    vec_cnt++; if (ds_to_es_valid !== 1'b0) begin fail_cnt++; $display("FAIL lu_es_valid got %b want 0", ds_to_es_valid); end
    vec_cnt++; if (ds_allowin !== 1'b0) begin fail_cnt++; $display("FAIL lu_allowin got %b want 0", ds_allowin); end
    tick();
    vec_cnt++; if (br_bus[33] !== 1'b1) begin fail_cnt++; $display("FAIL lu_hold got %b want 1", br_bus[33]); end
    es_fwd_bus = '0; ms_fwd_bus = {1'b1, 5'd4, 32'd1}; #1;
    vec_cnt++; if (br_bus !== 34'd0) begin fail_cnt++; $display("FAIL beq_nt got %h want 0", br_bus); end
    ms_fwd_bus = {1'b1, 5'd4, 32'd0}; #1;
    vec_cnt++; if (br_bus !== {1'b0, 1'b1, 32'h210}) begin fail_cnt++; $display("FAIL beq_t got %h want 100000210", br_bus); end
    vec_cnt++; if (ds_to_es_valid !== 1'b1) begin fail_cnt++; $display("FAIL beq_valid got %b want 1", ds_to_es_valid); end
    ms_fwd_bus = '0;
    tick();
    vec_cnt++; if (ds_to_es_valid !== 1'b0) begin fail_cnt++; $display("FAIL beq_drain got %b want 0", ds_to_es_valid); end
  endtask

  task automatic test_bne_jal();
    load(32'h14A6FFFF, 32'h100);
    vec_cnt++; if (br_bus !== {1'b0, 1'b1, 32'h100}) begin fail_cnt++; $display("FAIL bne got %h want 100000100", br_bus); end
    load(32'h0C000040, 32'hbfc00010);
    vec_cnt++; if (br_bus !== {1'b0, 1'b1, 32'hb0000100}) begin fail_cnt++; $display("FAIL jal_br got %h want 1b0000100", br_bus); end
    vec_cnt++; if (f_dest !== 5'd31) begin fail_cnt++; $display("FAIL jal_dest got %0d want 31", f_dest); end
    vec_cnt++; if ({f_gr_we, f_src1_is_pc, f_src2_is_8} !== 3'b111) begin fail_cnt++; $display("FAIL jal_flags got %b want 111", {f_gr_we, f_src1_is_pc, f_src2_is_8}); end
    tick();
  endtask

  task automatic test_nop();
    load(32'hFC000000, 32'h500);
    vec_cnt++; if (ds_to_es_valid !== 1'b1) begin fail_cnt++; $display("FAIL nop_valid got %b want 1", ds_to_es_valid); end
    vec_cnt++; if ({f_gr_we, f_mem_we} !== 2'b00) begin fail_cnt++; $display("FAIL nop_we got %b want 00", {f_gr_we, f_mem_we}); end
    vec_cnt++; if (br_bus !== 34'd0) begin fail_cnt++; $display("FAIL nop_br got %h want 0", br_bus); end
    tick();
  endtask

  task automatic test_back_to_back_jr_flush();
    es_allowin = 1'b0;
    load(32'h00E00008, 32'h300);
    for (int c = 0; c < 3; c++) begin
      vec_cnt++; if (ds_allowin !== 1'b0) begin fail_cnt++; $display("FAIL jr_allowin c%0d got %b want 0", c, ds_allowin); end
      vec_cnt++; if (br_bus !== {1'b0, 1'b1, 32'h80001234}) begin fail_cnt++; $display("FAIL jr_br c%0d got %h want 180001234", c, br_bus); end
      vec_cnt++; if (f_pc !== 32'h300) begin fail_cnt++; $display("FAIL jr_pc c%0d got %h want 300", c, f_pc); end
      if (c < 2) tick();
    end
    flush = 1'b1; es_allowin = 1'b1; fs_to_ds_valid = 1'b1; fs_to_ds_bus = {32'h24010005, 32'h304};
    tick();
    flush = 1'b0; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0; #1;
    vec_cnt++; if (ds_to_es_valid !== 1'b0) begin fail_cnt++; $display("FAIL flush_valid got %b want 0", ds_to_es_valid); end
    vec_cnt++; if (br_bus !== 34'd0) begin fail_cnt++; $display("FAIL flush_br got %h want 0", br_bus); end
    vec_cnt++; if (ds_allowin !== 1'b1) begin fail_cnt++; $display("FAIL flush_allowin got %b want 1", ds_allowin); end
  endtask

  task automatic test_reset_mid_stall();
    es_fwd_bus = {2'b11, 5'd4, 32'd0};
    load(32'h10800003, 32'h600);
    vec_cnt++; if (br_bus[33] !== 1'b1) begin fail_cnt++; $display("FAIL rs_stall got %b want 1", br_bus[33]); end
    reset = 1'b1; #1;
    vec_cnt++; if (ds_allowin !== 1'b1) begin fail_cnt++; $display("FAIL rs_in_allowin got %b want 1", ds_allowin); end
    vec_cnt++; if (br_bus !== 34'd0) begin fail_cnt++; $display("FAIL rs_in_br got %h want 0", br_bus); end
    tick();
    reset = 1'b0; es_fwd_bus = '0; #1;
    vec_cnt++; if (br_bus !== 34'd0) begin fail_cnt++; $display("FAIL rs_after_br got %h want 0", br_bus); end
    vec_cnt++; if (ds_to_es_valid !== 1'b0) begin fail_cnt++; $display("FAIL rs_after_valid got %b want 0", ds_to_es_valid); end
    tick();
    vec_cnt++; if (br_bus !== 34'd0) begin fail_cnt++; $display("FAIL rs_after2_br got %h want 0", br_bus); end
    es_allowin = 1'b0;
    load(32'h00A61821, 32'h700);
    vec_cnt++; if ({f_rs, f_rt} !== 64'd0) begin fail_cnt++; $display("FAIL rs_rf_clear got %h want 0", {f_rs, f_rt}); end
    es_allowin = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_regfile();
    test_fwd();
    test_load_use();
    test_bne_jal();
    test_nop();
    test_back_to_back_jr_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end
endmodule
